serial_sub_ctrl: RTL and testbench

Bit-serial subtraction controller that time-shares one 1-bit full-subtractor cell (`Full_Subtractor_3`) across a WIDTH-bit operation. It accepts A, B and an incoming borrow on a start pulse and steps the cell LSB-first, one bit per clock, holding the running borrow in a flop. It presents the WIDTH-bit difference and final borrow with a one-cycle `done` strobe. It sits between any requester needing occasional multi-bit subtraction and the single shared subtractor cell.

---
 rtl/sub_pkg.sv | 13 +
 rtl/serial_sub_ctrl_cell.sv | 14 +
 rtl/serial_sub_ctrl.sv | 130 +++++++++++++
 tb/tb_serial_sub_ctrl.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/sub_pkg.sv
// Shared definitions for the bit-serial subtraction controller.
// Controller state encoding and the default operand width.
package sub_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/serial_sub_ctrl_cell.sv
// One-bit full subtractor: D = X - Y - Z (mod 2), B = borrow out.
// Purely combinational; the shared cell stepped by the serial controller.
module Full_Subtractor_3 (
  output logic D,
  output logic B,
  input  logic X,
  input  logic Y,
  input  logic Z
);

  assign D = X ^ Y ^ Z;
  assign B = (~X & Y) | (~X & Z) | (Y & Z);

endmodule

// File: rtl/serial_sub_ctrl.sv
// Bit-serial WIDTH-bit subtractor: time-shares one full-subtractor cell LSB-first,
// producing diff = a - b - bin and the final borrow with a one-cycle done strobe.
module serial_sub_ctrl
  import sub_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_sa;
  logic [WIDTH-1:0] r_sb;
  logic [WIDTH-1:0] r_res;
  logic             r_br;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_diff;
  logic             r_bout;
  logic             r_busy;
  logic             r_done;

  logic             w_d;
  logic             w_b;
  logic             w_last;
  logic [WIDTH-1:0] w_res_nxt;

  Full_Subtractor_3 u_cell (
    .D (w_d),
    .B (w_b),
    .X (r_sa[0]),
    .Y (r_sb[0]),
    .Z (r_br)
  );

  assign w_last    = (r_state == RUN) && (r_cnt == LAST_BIT);
  // Shift the new difference bit in at the MSB; written this way so WIDTH=1 also works.
  assign w_res_nxt = WIDTH'({w_d, r_res} >> 1);

  // Next-state decode
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_state_nxt = RUN;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      RUN: begin
        if (w_last) begin
          w_state_nxt = DONE;
        end else begin
          w_state_nxt = RUN;
        end
      end
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // State register plus registered status flags derived from the next state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_busy  <= (w_state_nxt != IDLE);
      r_done  <= (w_state_nxt == DONE);
    end
  end

  // Operand shifters, running borrow, bit counter and result capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sa   <= '0;
      r_sb   <= '0;
      r_res  <= '0;
      r_br   <= 1'b0;
      r_cnt  <= '0;
      r_diff <= '0;
      r_bout <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_sa  <= a;
            r_sb  <= b;
            r_br  <= bin;
            r_cnt <= '0;
          end
        end
        RUN: begin
          r_sa  <= r_sa >> 1;
          r_sb  <= r_sb >> 1;
          r_res <= w_res_nxt;
          r_br  <= w_b;
          r_cnt <= r_cnt + CW'(1);
          if (w_last) begin
            r_diff <= w_res_nxt;
            r_bout <= w_b;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign diff = r_diff;
  assign bout = r_bout;

endmodule

// File: tb/tb_serial_sub_ctrl.sv
// Self-checking bench for serial_sub_ctrl: WIDTH=8 and WIDTH=1 instances checked
// every cycle against an arithmetic reference model, plus directed literal cases.
module tb_serial_sub_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start8 = 1'b0, bin8 = 1'b0, start1 = 1'b0, a1 = 1'b0, b1 = 1'b0, bin1 = 1'b0;
  logic [7:0] a8 = 8'd0, b8 = 8'd0;
  logic       busy8, done8, bout8, busy1, done1, bout1, diff1;
  logic [7:0] diff8;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  serial_sub_ctrl #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .bin(bin8),
    .busy(busy8), .done(done8), .diff(diff8), .bout(bout8)
  );

  serial_sub_ctrl #(.WIDTH(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1), .bin(bin1),
    .busy(busy1), .done(done1), .diff(diff1), .bout(bout1)
  );

  // Index 0 is the 8-bit instance, index 1 the 1-bit instance.
  logic       in_start [2];
  logic [7:0] in_a [2];
  logic [7:0] in_b [2];
  logic       in_bin [2];
  logic       o_busy [2];
  logic       o_done [2];
  logic [7:0] o_diff [2];
  logic       o_bout [2];

  assign in_start[0] = start8;  assign in_start[1] = start1;
  assign in_a[0] = a8;          assign in_a[1] = {7'd0, a1};
  assign in_b[0] = b8;          assign in_b[1] = {7'd0, b1};
  assign in_bin[0] = bin8;      assign in_bin[1] = bin1;
  assign o_busy[0] = busy8;     assign o_busy[1] = busy1;
  assign o_done[0] = done8;     assign o_done[1] = done1;
  assign o_diff[0] = diff8;     assign o_diff[1] = {7'd0, diff1};
  assign o_bout[0] = bout8;     assign o_bout[1] = bout1;

  function automatic int width_of(input int sel);
    return (sel == 0) ? 8 : 1;
  endfunction

  // {borrow, difference} of a - b - bin on w bits, by plain integer arithmetic.
  function automatic logic [8:0] ref_sub(input int w, input logic [7:0] x, input logic [7:0] y,
                                         input logic z);
    int v;
    int mask;
    v    = int'(x) - int'(y) - int'(z);
    mask = (1 << w) - 1;
    return {(v < 0), 8'(v & mask)};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: m_age is -1 when idle, else edges since the accepting edge.
  int         m_age [2];
  logic [7:0] m_a [2];
  logic [7:0] m_b [2];
  logic       m_bin [2];
  logic [7:0] m_diff [2];
  logic       m_bout [2];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        m_age[i]  <= -1;
        m_diff[i] <= 8'd0;
        m_bout[i] <= 1'b0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (m_age[i] < 0) begin
          if (in_start[i]) begin
            m_age[i] <= 0;
            m_a[i]   <= in_a[i];
            m_b[i]   <= in_b[i];
            m_bin[i] <= in_bin[i];
          end
        end else if (m_age[i] == width_of(i)) begin
          m_age[i] <= -1;
        end else begin
          m_age[i] <= m_age[i] + 1;
          if (m_age[i] + 1 == width_of(i))
            {m_bout[i], m_diff[i]} <= ref_sub(width_of(i), m_a[i], m_b[i], m_bin[i]);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      for (int i = 0; i < 2; i++) begin
        chk($sformatf("busy[w%0d]", width_of(i)), 32'(o_busy[i]), 32'(m_age[i] >= 0));
        chk($sformatf("done[w%0d]", width_of(i)), 32'(o_done[i]), 32'(m_age[i] == width_of(i)));
        chk($sformatf("diff[w%0d]", width_of(i)), 32'(o_diff[i]), 32'(m_diff[i]));
        chk($sformatf("bout[w%0d]", width_of(i)), 32'(o_bout[i]), 32'(m_bout[i]));
      end
    end
  end

  // Counts edges from the accepting edge (counted as 1) until done is seen.
  task automatic wait_done(input int sel, output int n);
    n = 1;
    do begin
      @(posedge clk);
      n++;
      @(negedge clk);
    end while (!o_done[sel] && n < 30);
    if (!o_done[sel]) chk("done_timeout", 32'(0), 32'(1));
  endtask

  task automatic drive(input int sel, input logic s, input logic [7:0] x, input logic [7:0] y,
                       input logic z);
    if (sel == 0) begin
      start8 = s; a8 = x; b8 = y; bin8 = z;
    end else begin
      start1 = s; a1 = x[0]; b1 = y[0]; bin1 = z;
    end
  endtask

  task automatic do_op(input int sel, input logic [7:0] x, input logic [7:0] y, input logic z,
                       input logic [7:0] ed, input logic eb);
    int n;
    @(negedge clk);
    drive(sel, 1'b1, x, y, z);
    @(posedge clk);
    @(negedge clk);
    drive(sel, 1'b0, 8'($urandom), 8'($urandom), 1'($urandom));
    wait_done(sel, n);
    chk("latency", 32'(n), 32'(width_of(sel) + 1));
    chk("op_diff", 32'(o_diff[sel]), 32'(ed));
    chk("op_bout", 32'(o_bout[sel]), 32'(eb));
    @(negedge clk);
    chk("done_one_cycle", 32'(o_done[sel]), 32'(0));
    chk("idle_after_done", 32'(o_busy[sel]), 32'(0));
  endtask

  initial begin
    int n;
    logic [8:0] r;
    #12;
    chk("rst_busy", 32'(busy8), 32'(0));
    chk("rst_done", 32'(done8), 32'(0));
    chk("rst_diff", 32'(diff8), 32'(0));
    chk("rst_bout", 32'(bout8), 32'(0));
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_after_rst", 32'(busy8), 32'(0));

    do_op(0, 8'h5A, 8'h3C, 1'b0, 8'h1E, 1'b0);
    do_op(0, 8'h00, 8'h01, 1'b0, 8'hFF, 1'b1);
    do_op(0, 8'h10, 8'h10, 1'b1, 8'hFF, 1'b1);
    do_op(0, 8'h80, 8'h7F, 1'b1, 8'h00, 1'b0);

    // Held start with toggling operands: first result unaffected, second uses
    // the operands present at the first IDLE edge.
    @(negedge clk);
    drive(0, 1'b1, 8'h21, 8'h13, 1'b0);
    @(posedge clk);
    n = 1;
    do begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (!done8) drive(0, 1'b1, 8'($urandom), 8'($urandom), 1'($urandom));
    end while (!done8 && n < 30);
    chk("ign_latency", 32'(n), 32'(9));
    chk("ign_diff1", 32'(diff8), 32'(8'h0E));
    chk("ign_bout1", 32'(bout8), 32'(0));
    drive(0, 1'b1, 8'h44, 8'h45, 1'b1);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    chk("ign_accepted", 32'(busy8), 32'(1));
    drive(0, 1'b0, 8'($urandom), 8'($urandom), 1'($urandom));
    wait_done(0, n);
    chk("ign_diff2", 32'(diff8), 32'(8'hFE));
    chk("ign_bout2", 32'(bout8), 32'(1));
    @(negedge clk);

    // Reset in the middle of an operation, with a nonzero previous result held.
    do_op(0, 8'h9C, 8'h21, 1'b0, 8'h7B, 1'b0);
    @(negedge clk);
    drive(0, 1'b1, 8'hC3, 8'h5E, 1'b1);
    @(posedge clk);
    @(negedge clk);
    drive(0, 1'b0, 8'h00, 8'h00, 1'b0);
    repeat (4) @(posedge clk);
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", 32'(busy8), 32'(0));
    chk("mid_rst_done", 32'(done8), 32'(0));
    chk("mid_rst_diff", 32'(diff8), 32'(0));
    chk("mid_rst_bout", 32'(bout8), 32'(0));
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      chk("no_done_after_rst", 32'(done8), 32'(0));
    end
    do_op(0, 8'h03, 8'h05, 1'b0, 8'hFE, 1'b1);

    // WIDTH=1 truth table, expectations from integer subtraction.
    for (int i = 0; i < 8; i++) begin
      r = ref_sub(1, 8'(i >> 2), 8'((i >> 1) & 1), 1'(i & 1));
      do_op(1, 8'(i >> 2), 8'((i >> 1) & 1), 1'(i & 1), r[7:0], r[8]);
    end

    // Random traffic on both instances; the per-cycle compare checks everything.
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      drive(0, ($urandom_range(0, 3) == 0), 8'($urandom), 8'($urandom), 1'($urandom));
      drive(1, ($urandom_range(0, 2) == 0), 8'($urandom), 8'($urandom), 1'($urandom));
    end
    @(negedge clk);
    drive(0, 1'b0, 8'd0, 8'd0, 1'b0);
    drive(1, 1'b0, 8'd0, 8'd0, 1'b0);
    repeat (14) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
